// File: rtl/midi_pkg.sv
// MIDI parser shared types: FSM states, message-type codes,
// byte classification and data-length helpers.
package midi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_D1,
    ST_WAIT_D2,
    ST_DISCARD
  } state_t;

  typedef enum logic [1:0] {
    BC_DATA,
    BC_STATUS,
    BC_SYS,
    BC_RT
  } byte_class_t;

  localparam logic [3:0] NOTE_OFF    = 4'h8;
  localparam logic [3:0] NOTE_ON     = 4'h9;
  localparam logic [3:0] POLY_PRESS  = 4'hA;
  localparam logic [3:0] CTRL_CHANGE = 4'hB;
  localparam logic [3:0] PROG_CHANGE = 4'hC;
  localparam logic [3:0] CHAN_PRESS  = 4'hD;
  localparam logic [3:0] PITCH_BEND  = 4'hE;

  function automatic byte_class_t byte_class(
    input logic [7:0] b
  );
    byte_class_t c;
    if (!b[7])
      c = BC_DATA;
    else if (b[7:4] != 4'hF)
      c = BC_STATUS;
    else if (b[3])
      c = BC_RT;
    else
      c = BC_SYS;
    return c;
  endfunction

  function automatic logic two_data(
    input logic [3:0] t
  );
    return !((t == PROG_CHANGE) ||
             (t == CHAN_PRESS));
  endfunction

endpackage

// File: rtl/midi_msg_parser.sv
// MIDI channel-message parser with running status,
// real-time passthrough and optional channel filter.
module midi_msg_parser
  import midi_pkg::*;
#(
  parameter logic       CHANNEL_FILTER_EN = 1'b0,
  parameter logic [3:0] CHANNEL           = 4'd0
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] byte_in,
  input  logic       byte_valid_in,
  output logic [3:0] status,
  output logic [3:0] channel,
  output logic [7:0] data_byte1,
  output logic [7:0] data_byte2,
  output logic       valid_out,
  output logic [7:0] drop_count
);

  state_t      r_state;
  state_t      w_next;
  byte_class_t w_cls;

  logic [7:0] r_rs;
  logic [7:0] r_d1;
  logic [3:0] r_status;
  logic [3:0] r_channel;
  logic [7:0] r_db1;
  logic [7:0] r_db2;
  logic       r_valid;
  logic [7:0] r_drop;

  logic       w_one;
  logic       w_is_data;
  logic       w_is_stat;
  logic       w_is_sys;
  logic       w_drop_inc;
  logic       w_lat_d1;
  logic       w_done;
  logic       w_match;
  logic       w_emit;
  logic [7:0] w_new_d1;
  logic [7:0] w_new_d2;

  assign w_cls     = byte_class(byte_in);
  assign w_one     = !two_data(r_rs[7:4]);
  assign w_is_data = byte_valid_in && (w_cls == BC_DATA);
  assign w_is_stat = byte_valid_in && (w_cls == BC_STATUS);
  assign w_is_sys  = byte_valid_in && (w_cls == BC_SYS);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)
      r_state <= ST_IDLE;
    else
      r_state <= w_next;
  end

  // real-time bytes match no arm and leave the state alone
  always_comb begin
    w_next = r_state;
    unique case (1'b1)
      w_is_sys:  w_next = ST_DISCARD;
      w_is_stat: w_next = ST_WAIT_D1;
      w_is_data: begin
        if (r_state == ST_WAIT_D1)
          w_next = w_one ? ST_WAIT_D1 : ST_WAIT_D2;
        else if (r_state == ST_WAIT_D2)
          w_next = ST_WAIT_D1;
      end
      default: w_next = r_state;
    endcase
  end

  always_comb begin
    w_drop_inc = w_is_data && (r_state == ST_IDLE);
    w_lat_d1   = w_is_data && (r_state == ST_WAIT_D1);
    w_done     = w_is_data &&
                 ((r_state == ST_WAIT_D2) ||
                  ((r_state == ST_WAIT_D1) && w_one));
    w_match    = !CHANNEL_FILTER_EN ||
                 (r_rs[3:0] == CHANNEL);
    w_emit     = w_done && w_match;
    w_new_d1   = (r_state == ST_WAIT_D1) ? byte_in : r_d1;
    w_new_d2   = w_one ? 8'd0 : byte_in;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_rs      <= 8'd0;
      r_d1      <= 8'd0;
      r_status  <= 4'd0;
      r_channel <= 4'd0;
      r_db1     <= 8'd0;
      r_db2     <= 8'd0;
      r_valid   <= 1'b0;
      r_drop    <= 8'd0;
    end else begin
      r_valid <= w_emit;
      if (w_is_stat)
        r_rs <= byte_in;
      else if (w_is_sys)
        r_rs <= 8'd0;
      if (w_lat_d1)
        r_d1 <= byte_in;
      if (w_emit) begin
        r_status  <= r_rs[7:4];
        r_channel <= r_rs[3:0];
        r_db1     <= w_new_d1;
        r_db2     <= w_new_d2;
      end
      if (w_drop_inc && (r_drop != 8'hFF))
        r_drop <= r_drop + 8'd1;
    end
  end

  assign status     = r_status;
  assign channel    = r_channel;
  assign data_byte1 = r_db1;
  assign data_byte2 = r_db2;
  assign valid_out  = r_valid;
  assign drop_count = r_drop;

endmodule
